vram_arb: RTL

- Shares the text video adapter's single Wishbone VRAM port between the CPU and a hardware screen-maintenance engine.
- The engine runs three operations over the 80x25 text buffer: scroll-up, clear-row and clear-screen.
- Row 0 is the service/status line and is never touched by the engine.
- Also generates the `flash` blink pulse consumed by the video adapter.

---
 rtl/vram_arb.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vram_arb.sv
// Arbitrates the single VRAM Wishbone port between the CPU and a scroll/clear
// engine. Define VRAM_ARB_FLASH_EN to build the `flash` blink divider.
module vram_arb #(
    parameter int unsigned ROWS      = 25,
    parameter int unsigned COLS      = 80,
    parameter int unsigned FIRST_ROW = 1,
    parameter logic [15:0] FILL      = 16'h2020,
    parameter int unsigned FLASH_DIV = 25000000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] s_adr_i,
    input  logic [15:0] s_dat_i,
    output logic [15:0] s_dat_o,
    input  logic        s_cyc_i,
    input  logic        s_stb_i,
    input  logic        s_we_i,
    input  logic [1:0]  s_sel_i,
    output logic        s_ack_o,
    output logic [15:0] m_adr_o,
    output logic [15:0] m_dat_o,
    input  logic [15:0] m_dat_i,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [1:0]  m_sel_o,
    input  logic        m_ack_i,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_row,
    output logic        cmd_ready,
    output logic        busy,
    output logic        done,
    output logic        flash
);
    localparam logic [10:0] PITCH      = 11'(COLS / 2);
    localparam logic [10:0] BODY_START = 11'(FIRST_ROW * (COLS / 2));
    localparam logic [10:0] LAST_START = 11'((ROWS - 1) * (COLS / 2));
    localparam logic [10:0] SCREEN_END = 11'(ROWS * (COLS / 2));

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_ENG} owner_e;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_NEXT, S_DONE} eng_state_e;
    typedef enum logic [1:0] {OP_SCROLL, OP_CLR_ROW, OP_CLR_SCR, OP_RSVD} op_e;

    owner_e      owner_q, owner_d, last_q, last_d;
    logic        m_cyc_q, m_cyc_d, m_we_q, m_we_d;
    logic [15:0] m_adr_q, m_adr_d, m_dat_q, m_dat_d, s_dat_q, s_dat_d;
    logic [1:0]  m_sel_q, m_sel_d;
    eng_state_e  state_q, state_d;
    op_e         op_q, op_d;
    logic [4:0]  row_q, row_d;
    logic [10:0] w_q, w_d, end_q, end_d;
    logic        fill_q, fill_d;
    logic [15:0] hold_q, hold_d;

    logic        cpu_req, eng_req, cpu_ack, eng_ack, cmd_bad;
    logic [10:0] eng_word, row_base;

    assign cpu_req  = s_cyc_i & s_stb_i;
    assign eng_req  = (state_q == S_RD) || (state_q == S_WR);
    assign cpu_ack  = m_ack_i & (owner_q == OWN_CPU);
    assign eng_ack  = m_ack_i & (owner_q == OWN_ENG);
    assign eng_word = (state_q == S_RD) ? w_q + PITCH : w_q;
    assign row_base = 11'(row_q) * PITCH;
    assign cmd_bad  = (cmd_op == 2'd3) ||
                      ((cmd_op == 2'd1) && ((32'(cmd_row) < FIRST_ROW) || (32'(cmd_row) >= ROWS)));

    assign s_ack_o   = cpu_ack;
    assign s_dat_o   = cpu_ack ? m_dat_i : s_dat_q;
    assign m_cyc_o   = m_cyc_q;
    assign m_stb_o   = m_cyc_q;
    assign m_we_o    = m_we_q;
    assign m_adr_o   = m_adr_q;
    assign m_dat_o   = m_dat_q;
    assign m_sel_o   = m_sel_q;
    assign cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy      = !cmd_ready;
    assign done      = (state_q == S_DONE);

    // On contention the grant goes to whichever side did not win last time.
    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        m_cyc_d = m_cyc_q;
        m_we_d  = m_we_q;
        m_adr_d = m_adr_q;
        m_dat_d = m_dat_q;
        m_sel_d = m_sel_q;
        s_dat_d = s_dat_q;
        unique case (owner_q)
            OWN_NONE: begin
                if (cpu_req && (!eng_req || last_q != OWN_CPU)) begin
                    owner_d = OWN_CPU;
                    last_d  = OWN_CPU;
                    m_cyc_d = 1'b1;
                    m_we_d  = s_we_i;
                    m_adr_d = s_adr_i;
                    m_dat_d = s_dat_i;
                    m_sel_d = s_sel_i;
                end else if (eng_req) begin
                    owner_d = OWN_ENG;
                    last_d  = OWN_ENG;
                    m_cyc_d = 1'b1;
                    m_we_d  = (state_q == S_WR);
                    m_adr_d = {4'b0, eng_word, 1'b0};
                    m_dat_d = fill_q ? FILL : hold_q;
                    m_sel_d = '1;
                end
            end
            OWN_CPU: begin
                if (!s_cyc_i) begin
                    owner_d = OWN_NONE;
                    m_cyc_d = 1'b0;
                end else if (m_ack_i) begin
                    owner_d = OWN_NONE;
                    m_cyc_d = 1'b0;
                    s_dat_d = m_dat_i;
                end
            end
            OWN_ENG: begin
                if (m_ack_i) begin
                    owner_d = OWN_NONE;
                    m_cyc_d = 1'b0;
                end
            end
            default: owner_d = OWN_NONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        row_d   = row_q;
        w_d     = w_q;
        end_d   = end_q;
        fill_d  = fill_q;
        hold_d  = hold_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    row_d   = cmd_row;
                    state_d = cmd_bad ? S_DONE : S_NEXT;
                end
            end
            S_NEXT: begin
                fill_d  = (op_q != OP_SCROLL);
                state_d = (op_q == OP_SCROLL) ? S_RD : S_WR;
                unique case (op_q)
                    OP_SCROLL: begin
                        w_d   = BODY_START;
                        end_d = LAST_START;
                    end
                    OP_CLR_ROW: begin
                        w_d   = row_base;
                        end_d = row_base + PITCH;
                    end
                    default: begin
                        w_d   = BODY_START;
                        end_d = SCREEN_END;
                    end
                endcase
            end
            S_RD: begin
                if (eng_ack) begin
                    hold_d  = m_dat_i;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                // Scroll copy runs into its fill phase without leaving WR.
                if (eng_ack) begin
                    w_d = w_q + 11'd1;
                    if (w_q + 11'd1 == end_q) begin
                        if (!fill_q) begin
                            fill_d = 1'b1;
                            end_d  = SCREEN_END;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = fill_q ? S_WR : S_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            owner_q <= OWN_NONE;
            last_q  <= OWN_ENG;
            m_cyc_q <= 1'b0;
            m_we_q  <= 1'b0;
            m_adr_q <= '0;
            m_dat_q <= '0;
            m_sel_q <= '0;
            s_dat_q <= '0;
            state_q <= S_IDLE;
            op_q    <= OP_SCROLL;
            row_q   <= '0;
            w_q     <= '0;
            end_q   <= '0;
            fill_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            m_cyc_q <= m_cyc_d;
            m_we_q  <= m_we_d;
            m_adr_q <= m_adr_d;
            m_dat_q <= m_dat_d;
            m_sel_q <= m_sel_d;
            s_dat_q <= s_dat_d;
            state_q <= state_d;
            op_q    <= op_d;
            row_q   <= row_d;
            w_q     <= w_d;
            end_q   <= end_d;
            fill_q  <= fill_d;
            hold_q  <= hold_d;
        end
    end

    if (FLASH_DIV == 0 || FLASH_DIV > (1 << 25)) begin : g_bad_flash_div
        $error("vram_arb: FLASH_DIV must be within 1..2**25");
    end

`ifdef VRAM_ARB_FLASH_EN
    logic [24:0] flash_cnt_q, flash_cnt_d;
    logic        flash_q, flash_d;

    always_comb begin
        flash_cnt_d = flash_cnt_q + 25'd1;
        flash_d     = flash_q;
        if (flash_cnt_q == 25'(FLASH_DIV - 1)) begin
            flash_cnt_d = '0;
            flash_d     = ~flash_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            flash_cnt_q <= '0;
            flash_q     <= 1'b1;
        end else begin
            flash_cnt_q <= flash_cnt_d;
            flash_q     <= flash_d;
        end
    end

    assign flash = flash_q;
`else
    assign flash = 1'b1;
`endif
endmodule
